// File: rtl/rap_cla_pipe.sv
// rap_cla_pipe: registered windowed-speculation adder behind a valid/ready handshake.
// Define RAPCLA_CORRECT_EN to add a one-cycle stall that replaces mis-speculated results with the exact sum.
module rap_cla_pipe #(
    parameter int WIDTH = 32,
    parameter int WIN   = 4,
    parameter int ERRW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             approx_err,
    output logic             corrected,
    output logic [ERRW-1:0]  err_cnt
);
`ifdef RAPCLA_CORRECT_EN
    typedef enum logic [1:0] {IDLE, HOLD, FIX} state_t;
`else
    typedef enum logic {IDLE, HOLD} state_t;
`endif
    state_t state;
    logic [WIDTH-1:0] p, g;
    logic [WIDTH:0] ac, approx, exact;
    logic c, err, accept;
    assign p = a ^ b;
    assign g = a & b;
    // carry into bit i only sees the WIN bits below it; cin enters only when the window reaches bit 0
    always_comb begin
        c = 1'b0;
        ac = '0;
        ac[0] = cin;
        for (int i = 1; i <= WIDTH; i++) begin
            c = (i <= WIN) ? cin : 1'b0;
            for (int j = 0; j < WIDTH; j++)
                if (j >= i - WIN && j < i) c = g[j] | (p[j] & c);
            ac[i] = c;
        end
    end
    assign approx = {ac[WIDTH], p ^ ac[WIDTH-1:0]};
    assign exact  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    assign err    = approx != exact;
    assign out_valid = state == HOLD;
`ifdef RAPCLA_CORRECT_EN
    logic [WIDTH:0] fix_res;
    assign in_ready = (state != FIX) && (!out_valid || out_ready);
`else
    assign in_ready  = !out_valid || out_ready;
    assign corrected = 1'b0;
`endif
    assign accept = in_valid && in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sum        <= '0;
            cout       <= 1'b0;
            approx_err <= 1'b0;
            err_cnt    <= '0;
`ifdef RAPCLA_CORRECT_EN
            corrected  <= 1'b0;
            fix_res    <= '0;
`endif
        end else begin
            if (out_valid && out_ready) state <= IDLE;
            if (accept) begin
                sum        <= approx[WIDTH-1:0];
                cout       <= approx[WIDTH];
                approx_err <= err;
                if (err && err_cnt != '1) err_cnt <= err_cnt + ERRW'(1);
`ifdef RAPCLA_CORRECT_EN
                corrected  <= 1'b0;
                fix_res    <= exact;
                state      <= err ? FIX : HOLD;
`else
                state      <= HOLD;
`endif
            end
`ifdef RAPCLA_CORRECT_EN
            if (state == FIX) begin
                {cout, sum} <= fix_res;
                corrected   <= 1'b1;
                state       <= HOLD;
            end
`endif
        end
    end
endmodule

// File: tb/tb_rap_cla_pipe.sv
// tb_rap_cla_pipe: directed self-checking bench for rap_cla_pipe (both RAPCLA_CORRECT_EN builds).
module tb_rap_cla_pipe;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic in_ready, out_valid, cout, approx_err, corrected;
    logic [31:0] sum;
    logic [15:0] err_cnt;
    logic s_in_ready, s_out_valid, s_cout, s_approx_err, s_corrected;
    logic [31:0] s_sum;
    logic [1:0] s_err_cnt;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    rap_cla_pipe #(.WIDTH(32), .WIN(4), .ERRW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .approx_err(approx_err), .corrected(corrected), .err_cnt(err_cnt));

    rap_cla_pipe #(.WIDTH(32), .WIN(4), .ERRW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .cin(cin),
        .out_valid(s_out_valid), .out_ready(out_ready), .sum(s_sum), .cout(s_cout),
        .approx_err(s_approx_err), .corrected(s_corrected), .err_cnt(s_err_cnt));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // present one operand set at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] s_apx, input logic c_apx,
                                 input logic [31:0] s_ex, input logic c_ex, input logic e);
`ifdef RAPCLA_CORRECT_EN
        if (e) begin
            chk({tag, "_fix_valid"}, 64'(out_valid), 64'd0);
            chk({tag, "_fix_ready"}, 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        chk({tag, "_sum"}, 64'(sum), 64'(s_ex));
        chk({tag, "_cout"}, 64'(cout), 64'(c_ex));
        chk({tag, "_corr"}, 64'(corrected), 64'(e));
`else
        chk({tag, "_sum"}, 64'(sum), 64'(s_apx));
        chk({tag, "_cout"}, 64'(cout), 64'(c_apx));
        chk({tag, "_corr"}, 64'(corrected), 64'd0);
`endif
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_err"}, 64'(approx_err), 64'(e));
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_err", 64'(approx_err), 64'd0);
        chk("rst_corr", 64'(corrected), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'h0000000F, 32'h00000001, 1'b0);
        expect_result("exact", 32'h00000010, 1'b0, 32'h00000010, 1'b0, 1'b0);
        chk("exact_cnt", 64'(err_cnt), 64'd0);

        send(32'h0000001F, 32'h00000001, 1'b0);
        chk("err1_cnt", 64'(err_cnt), 64'd1);
        chk("sat0", 64'(s_err_cnt), 64'(sat_exp[0]));
        expect_result("err1", 32'h00000000, 1'b0, 32'h00000020, 1'b0, 1'b1);

        send(32'hFFFFFFFF, 32'h00000001, 1'b0);
        chk("ovf_cnt", 64'(err_cnt), 64'd2);
        chk("sat1", 64'(s_err_cnt), 64'(sat_exp[1]));
        expect_result("ovf", 32'hFFFFFFE0, 1'b0, 32'h00000000, 1'b1, 1'b1);

        for (int k = 2; k < 5; k++) begin
            send(32'h0000001F, 32'h00000001, 1'b0);
            chk($sformatf("sat%0d", k), 64'(s_err_cnt), 64'(sat_exp[k]));
            expect_result($sformatf("satr%0d", k), 32'h00000000, 1'b0, 32'h00000020, 1'b0, 1'b1);
        end
        chk("cnt5", 64'(err_cnt), 64'd5);

        // carry-in only reaches bits inside the window: 0xE + 0 + cin -> exact 0xF
        send(32'h0000000E, 32'h00000000, 1'b1);
        expect_result("cin", 32'h0000000F, 1'b0, 32'h0000000F, 1'b0, 1'b0);
        @(negedge clk);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // backpressure: four carry-free operand pairs, sum = i*0x101
        out_ready = 1'b0;
        a = 32'd0; b = 32'd0; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 32'd1; b = 32'h100;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold_valid%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp_hold_ready%0d", k), 64'(in_ready), 64'd0);
            chk($sformatf("bp_hold_sum%0d", k), 64'(sum), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("bp_sum%0d", k), 64'(sum), 64'(k * 32'h101));
            chk($sformatf("bp_valid%0d", k), 64'(out_valid), 64'd1);
            a = 32'(k + 1); b = 32'((k + 1) * 32'h100);
            if (k == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("bp_done", 64'(out_valid), 64'd0);
        chk("bp_cnt", 64'(err_cnt), 64'd5);

        // async reset while an erroneous result is in flight (FIX or HOLD)
        send(32'h0000001F, 32'h00000001, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_cnt", 64'(err_cnt), 64'd0);
        chk("arst_err", 64'(approx_err), 64'd0);
        chk("arst_corr", 64'(corrected), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send(32'h0000000F, 32'h00000001, 1'b0);
        expect_result("post", 32'h00000010, 1'b0, 32'h00000010, 1'b0, 1'b0);
        chk("post_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
